// File: rtl/pipeline_run_monitor.sv
// End-of-run controller for the MIPS CPU: detects program end from WB retirement,
// freezes the core and streams a register-file and data-memory dump over valid/ready.
module pipeline_run_monitor #(
  parameter int unsigned MAX_CYCLES = 305,
  parameter int unsigned CNT_W      = 16,
  parameter logic [31:0] HALT_PC    = 32'h0000_3FFC,
  parameter int unsigned LOOP_LIMIT = 4,
  parameter int unsigned DUMP_REGS  = 32,
  parameter int unsigned MEM_BASE   = 80,
  parameter int unsigned MEM_WORDS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic [31:0]      dm_raddr,
  input  logic [31:0]      dm_rdata,
  output logic             cpu_hold,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic             dump_kind,
  output logic [7:0]       dump_index,
  output logic [31:0]      dump_data,
  output logic             done,
  output logic [1:0]       stop_reason,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {StRun, StDumpRf, StDumpMem, StDone} state_e;

  localparam logic [1:0]       ReasonTimeout = 2'd1;
  localparam logic [1:0]       ReasonHalt    = 2'd2;
  localparam logic [1:0]       ReasonLoop    = 2'd3;
  localparam logic [7:0]       LastReg       = 8'(DUMP_REGS - 1);
  localparam logic [7:0]       LastWord      = 8'((MEM_WORDS == 0) ? 0 : MEM_WORDS - 1);
  localparam logic [CNT_W-1:0] LastCycle     = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]      LoopLast      = 32'(LOOP_LIMIT - 1);
  localparam logic [31:0]      MemBaseWord   = 32'(MEM_BASE / 4);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      loop_cnt_q, loop_cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       stop_reason_q, stop_reason_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             dump_valid_q, dump_valid_d;
  logic             done_q, done_d;

  logic same_pc, hit_halt, hit_loop, hit_timeout, xfer;

  assign same_pc     = (wb_pc == last_pc_q);
  assign hit_halt    = wb_valid && (wb_pc == HALT_PC);
  // This retirement would make the run of identical PCs reach LOOP_LIMIT.
  assign hit_loop    = wb_valid && same_pc && (loop_cnt_q == LoopLast);
  assign hit_timeout = (cycle_count_q == LastCycle);
  assign xfer        = dump_valid_q && dump_ready;

  always_comb begin
    state_d         = state_q;
    cycle_count_d   = cycle_count_q;
    retired_count_d = retired_count_q;
    last_pc_d       = last_pc_q;
    loop_cnt_d      = loop_cnt_q;
    idx_d           = idx_q;
    stop_reason_d   = stop_reason_q;
    cpu_hold_d      = cpu_hold_q;
    dump_valid_d    = dump_valid_q;
    done_d          = done_q;

    unique case (state_q)
      StRun: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        if (wb_valid) begin
          retired_count_d = retired_count_q + CNT_W'(1);
          loop_cnt_d      = same_pc ? loop_cnt_q + 32'd1 : 32'd1;
          last_pc_d       = wb_pc;
        end
        if (hit_halt || hit_loop || hit_timeout) begin
          stop_reason_d = hit_halt ? ReasonHalt : (hit_loop ? ReasonLoop : ReasonTimeout);
          cpu_hold_d    = 1'b1;
          dump_valid_d  = 1'b1;
          idx_d         = '0;
          state_d       = StDumpRf;
        end
      end
      StDumpRf: begin
        if (xfer) begin
          if (idx_q == LastReg) begin
            idx_d = '0;
            if (MEM_WORDS == 0) begin
              dump_valid_d = 1'b0;
              done_d       = 1'b1;
              state_d      = StDone;
            end else begin
              state_d = StDumpMem;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StDumpMem: begin
        if (xfer) begin
          if (idx_q == LastWord) begin
            idx_d        = '0;
            dump_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = StDone;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StDone: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StRun;
      cycle_count_q   <= '0;
      retired_count_q <= '0;
      last_pc_q       <= '0;
      loop_cnt_q      <= '0;
      idx_q           <= '0;
      stop_reason_q   <= '0;
      cpu_hold_q      <= 1'b0;
      dump_valid_q    <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
      last_pc_q       <= last_pc_d;
      loop_cnt_q      <= loop_cnt_d;
      idx_q           <= idx_d;
      stop_reason_q   <= stop_reason_d;
      cpu_hold_q      <= cpu_hold_d;
      dump_valid_q    <= dump_valid_d;
      done_q          <= done_d;
    end
  end

  // Payload fields follow the registered index; everything else is a flop.
  always_comb begin
    rf_raddr   = '0;
    dm_raddr   = '0;
    dump_kind  = 1'b0;
    dump_index = '0;
    dump_data  = '0;
    unique case (state_q)
      StDumpRf: begin
        rf_raddr   = idx_q[4:0];
        dump_index = idx_q;
        dump_data  = (idx_q == 8'd0) ? 32'd0 : rf_rdata;
      end
      StDumpMem: begin
        dump_kind  = 1'b1;
        dump_index = idx_q;
        dm_raddr   = MemBaseWord + 32'(idx_q);
        dump_data  = dm_rdata;
      end
      default: ;
    endcase
  end

  assign cpu_hold      = cpu_hold_q;
  assign dump_valid    = dump_valid_q;
  assign done          = done_q;
  assign stop_reason   = stop_reason_q;
  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;

endmodule
